// File: rtl/cpu_io_pkg.sv
// Shared encodings and widths for the CPU board I/O bridge blocks.
package cpu_io_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRESS_DB = 3'd1;
    localparam logic [2:0] ST_FIRE     = 3'd2;
    localparam logic [2:0] ST_WAIT_REL = 3'd3;
    localparam logic [2:0] ST_REL_DB   = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        PRESS_DB = ST_PRESS_DB,
        FIRE     = ST_FIRE,
        WAIT_REL = ST_WAIT_REL,
        REL_DB   = ST_REL_DB
    } btn_state_t;

    localparam int T9_PAD_WIDTH = 8;
    localparam int SW_WIDTH     = 24;
    localparam int DB_CNT_WIDTH = 20;

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer plus press/release debounce FSM; flags the cycle a press is accepted.
module btn_debounce
    import cpu_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_btn,
    output logic accept,
    output logic busy
);

    localparam logic [DB_CNT_WIDTH-1:0] CNT_MAX = DB_CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    btn_state_t              state_reg;
    logic [DB_CNT_WIDTH-1:0] cnt_reg;
    logic [1:0]              sync_reg;
    logic                    btn_s;

    assign btn_s = sync_reg[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sync_reg  <= '0;
        end else begin
            sync_reg <= {sync_reg[0], raw_btn};
            case (state_reg)
                IDLE: begin
                    if (btn_s) begin
                        state_reg <= PRESS_DB;
                        cnt_reg   <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!btn_s)
                        state_reg <= IDLE;
                    else if (cnt_reg == CNT_MAX)
                        state_reg <= FIRE;
                    else
                        cnt_reg <= cnt_reg + 1'b1;
                end
                FIRE: state_reg <= WAIT_REL;
                WAIT_REL: begin
                    if (!btn_s) begin
                        state_reg <= REL_DB;
                        cnt_reg   <= '0;
                    end
                end
                REL_DB: begin
                    if (btn_s)
                        state_reg <= WAIT_REL;
                    else if (cnt_reg == CNT_MAX)
                        state_reg <= IDLE;
                    else
                        cnt_reg <= cnt_reg + 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // High on the edge that moves PRESS_DB into FIRE, so the parent can register with it.
    assign accept = (state_reg == PRESS_DB) && btn_s && (cnt_reg == CNT_MAX);
    assign busy   = (state_reg != IDLE);

endmodule

// File: rtl/reg_io_bridge.sv
// Bridges board switches/button into CPU register $25 and mirrors register $24 onto the LEDs.
module reg_io_bridge
    import cpu_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic                confirm_btn,
    input  logic [31:0]         t8_value,
    output logic                outter_input,
    output logic [31:0]         outter_t9,
    output logic [SW_WIDTH-1:0] led,
    output logic                t8_changed,
    output logic                busy
);

    logic [SW_WIDTH-1:0] sw_meta_reg;
    logic [SW_WIDTH-1:0] sw_s;
    logic                accept;
    logic                outter_input_reg;
    logic [31:0]         outter_t9_reg;
    logic [31:0]         t8_held_reg;
    logic                t8_changed_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SW_WIDTH; gi++) begin : g_sw_sync
            always_ff @(posedge clock) begin
                if (reset) begin
                    sw_meta_reg[gi] <= 1'b0;
                    sw_s[gi]        <= 1'b0;
                end else begin
                    sw_meta_reg[gi] <= switches[gi];
                    sw_s[gi]        <= sw_meta_reg[gi];
                end
            end
        end
    endgenerate

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clock  (clock),
        .reset  (reset),
        .raw_btn(confirm_btn),
        .accept (accept),
        .busy   (busy)
    );

    // Strobe and data land together, so $25 sees the new value during the FIRE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            outter_input_reg <= 1'b0;
            outter_t9_reg    <= '0;
        end else begin
            outter_input_reg <= accept;
            if (accept)
                outter_t9_reg <= {{T9_PAD_WIDTH{1'b0}}, sw_s};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            t8_held_reg    <= '0;
            t8_changed_reg <= 1'b0;
        end else begin
            t8_changed_reg <= (t8_value != t8_held_reg);
            t8_held_reg    <= t8_value;
        end
    end

    assign outter_input = outter_input_reg;
    assign outter_t9    = outter_t9_reg;
    assign led          = t8_held_reg[SW_WIDTH-1:0];
    assign t8_changed   = t8_changed_reg;

endmodule

// File: tb/tb_reg_io_bridge.sv
// Directed bench for reg_io_bridge with a short debounce window.
module tb_reg_io_bridge;

    logic        clock;
    logic        reset;
    logic [23:0] switches;
    logic        confirm_btn;
    logic [31:0] t8_value;
    logic        outter_input;
    logic [31:0] outter_t9;
    logic [23:0] led;
    logic        t8_changed;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int strobe_count = 0;
    logic [31:0] strobe_t9 = '0;
    int base;

    reg_io_bridge #(.DEBOUNCE_CYCLES(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .switches    (switches),
        .confirm_btn (confirm_btn),
        .t8_value    (t8_value),
        .outter_input(outter_input),
        .outter_t9   (outter_t9),
        .led         (led),
        .t8_changed  (t8_changed),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (outter_input) begin
            strobe_count = strobe_count + 1;
            strobe_t9    = outter_t9;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            failures = failures + 1;
            $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end else begin
            $display("ok   %s observed=%h", tag, observed);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        switches    = '0;
        confirm_btn = 1'b0;
        t8_value    = '0;
        step(3);
        check_value("rst_outter_input", {31'd0, outter_input}, 32'd0);
        check_value("rst_outter_t9", outter_t9, 32'd0);
        check_value("rst_led", {8'd0, led}, 32'd0);
        check_value("rst_t8_changed", {31'd0, t8_changed}, 32'd0);
        check_value("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        step(2);

        // Clean press held 20 cycles, then release.
        base        = strobe_count;
        switches    = 24'h00A5F3;
        confirm_btn = 1'b1;
        step(20);
        check_value("press_busy_held", {31'd0, busy}, 32'd1);
        confirm_btn = 1'b0;
        step(20);
        check_value("press_strobes", strobe_count - base, 32'd1);
        check_value("press_t9_at_strobe", strobe_t9, 32'h0000A5F3);
        check_value("press_t9_hold", outter_t9, 32'h0000A5F3);
        check_value("press_busy_after", {31'd0, busy}, 32'd0);
        check_value("press_strobe_low", {31'd0, outter_input}, 32'd0);

        // Short glitch shorter than the debounce window.
        base        = strobe_count;
        confirm_btn = 1'b1;
        step(2);
        confirm_btn = 1'b0;
        step(12);
        check_value("short_strobes", strobe_count - base, 32'd0);
        check_value("short_busy", {31'd0, busy}, 32'd0);

        // Long hold with a one-cycle low glitch in the middle.
        base        = strobe_count;
        switches    = 24'h000777;
        confirm_btn = 1'b1;
        step(50);
        confirm_btn = 1'b0;
        step(1);
        confirm_btn = 1'b1;
        step(49);
        confirm_btn = 1'b0;
        step(20);
        check_value("glitch_strobes", strobe_count - base, 32'd1);
        check_value("glitch_busy", {31'd0, busy}, 32'd0);

        // Reset lands on the edge that would enter FIRE.
        base        = strobe_count;
        switches    = 24'hFFFFFF;
        confirm_btn = 1'b1;
        step(6);
        check_value("rstfire_busy_pre", {31'd0, busy}, 32'd1);
        reset       = 1'b1;
        confirm_btn = 1'b0;
        step(3);
        reset = 1'b0;
        step(20);
        check_value("rstfire_strobes", strobe_count - base, 32'd0);
        check_value("rstfire_t9", outter_t9, 32'd0);
        check_value("rstfire_strobe_low", {31'd0, outter_input}, 32'd0);
        check_value("rstfire_busy", {31'd0, busy}, 32'd0);

        // Back-to-back $24 updates.
        check_value("t8_idle_changed", {31'd0, t8_changed}, 32'd0);
        t8_value = 32'h12345678;
        step(1);
        check_value("t8_pulse1", {31'd0, t8_changed}, 32'd1);
        check_value("t8_led1", {8'd0, led}, 32'h00345678);
        t8_value = 32'h12345679;
        step(1);
        check_value("t8_pulse2", {31'd0, t8_changed}, 32'd1);
        check_value("t8_led2", {8'd0, led}, 32'h00345679);
        step(1);
        check_value("t8_pulse_end", {31'd0, t8_changed}, 32'd0);
        check_value("t8_led_final", {8'd0, led}, 32'h00345679);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
